// File: rtl/wishbone_slave_ram_pkg.sv
// Shared bus constants for the Wishbone RAM slave.
// FSM encodings, request bundle and the out-of-window read value.
package wishbone_slave_ram_pkg;

    localparam int WB_DW     = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_LANE_W = 8;

    localparam logic [WB_DW-1:0] WB_OOW_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } wb_state_e;

    typedef struct packed {
        logic                we;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_DW-1:0]    data;
        logic                tag;
    } wb_req_t;

endpackage

// File: rtl/wishbone_slave_ram_array.sv
// Word RAM: one write port with byte enables, one registered read port.
// Contents are not reset; only the read register clears.
module wb_ram_array
    import wishbone_slave_ram_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [WB_SEL_W-1:0] wr_be,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WB_DW-1:0]    wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [WB_DW-1:0]    rd_data
);

    logic [WB_DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*WB_LANE_W +: WB_LANE_W] <=
                        wr_data[i*WB_LANE_W +: WB_LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/wishbone_slave_ram.sv
// Wishbone classic slave in front of a word RAM with a single-cycle ACK.
// Optional wait states are built only when WB_SLAVE_RAM_WAIT_EN is defined.
module wishbone_slave_ram
    import wishbone_slave_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    input  logic                  i_CYC,
    output logic                  o_ACK,
    input  logic                  i_TAGN,
    output logic                  o_TAGN
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    wb_state_e             state;
    wb_state_e             state_nxt;
    wb_req_t               req_in;
    wb_req_t               req_q;
    wb_req_t               req_cur;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_cur;
    logic [IDX_W-1:0]      idx;
    logic                  start;
    logic                  in_win;
    logic                  enter_ack;
    logic                  cnt_zero;
    logic                  oow_q;
    logic [WB_DW-1:0]      ram_rdata;
    logic                  unused_addr;

    assign start  = i_CYC & i_STB;
    assign req_in = '{we: i_WE, sel: i_SEL, data: i_DATA, tag: i_TAGN};

    // From IDLE the live bus feeds the RAM so a zero-wait ACK has data ready.
    assign req_cur  = (state == ST_IDLE) ? req_in : req_q;
    assign addr_cur = (state == ST_IDLE) ? i_ADDR : addr_q;

    assign idx    = addr_cur[IDX_W+1:2];
    assign in_win = addr_cur[ADDR_WIDTH-1:IDX_W+2] ==
                    BASE_ADDR[ADDR_WIDTH-1:IDX_W+2];

    assign unused_addr = ^addr_cur[1:0];

`ifdef WB_SLAVE_RAM_WAIT_EN
    localparam bit HAS_WAIT = (WAIT_STATES != 0);
    localparam int CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [CNT_W-1:0] cnt_q;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt_q <= '0;
        end else if (state == ST_IDLE && start) begin
            cnt_q <= CNT_LOAD;
        end else if (state == ST_WAIT && !i_CYC) begin
            cnt_q <= '0;
        end else if (state == ST_WAIT && !cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
`else
    localparam bit HAS_WAIT = 1'b0;
    localparam int unused_wait_states = WAIT_STATES;

    assign cnt_zero = 1'b1;
`endif

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = HAS_WAIT ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (!i_CYC) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_zero) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ACK always exits to IDLE, so this is a single-cycle pulse.
    assign enter_ack = (state_nxt == ST_ACK);
    assign o_ACK     = (state == ST_ACK);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            req_q  <= '0;
            addr_q <= '0;
        end else if (state == ST_IDLE && start) begin
            req_q  <= req_in;
            addr_q <= i_ADDR;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_TAGN <= 1'b0;
            oow_q  <= 1'b0;
        end else if (enter_ack) begin
            o_TAGN <= req_cur.tag;
            if (!req_cur.we) begin
                oow_q <= !in_win;
            end
        end
    end

    assign o_DATA = oow_q ? WB_OOW_RDATA : ram_rdata;

    wb_ram_array #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk     (i_CLK),
        .rst     (i_RST),
        .wr_en   (enter_ack & req_cur.we & in_win),
        .wr_be   (req_cur.sel),
        .wr_addr (idx),
        .wr_data (req_cur.data),
        .rd_en   (enter_ack & ~req_cur.we & in_win),
        .rd_addr (idx),
        .rd_data (ram_rdata)
    );

endmodule
